// File: rtl/cronometro_progressivo.sv
// cronometro_progressivo: BCD stopwatch with start/pause/clear and saturation at 9999
module cronometro_progressivo #(
   parameter int TICK_DIV = 50000
) (
   input  logic        clock,
   input  logic        clr,
   input  logic        iniciar,
   input  logic        parar,
   input  logic        zerar,
   output logic [15:0] Q,
   output logic        contando,
   output logic        pronto,
   output logic        estouro
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   typedef enum logic [1:0] {INICIAL, CONTANDO, PARADO, ESTOURO} estado_t;
   estado_t estado, estado_nxt;
   logic [PW-1:0] presc, presc_nxt;
   logic [15:0] q_nxt, q_inc;
   logic pronto_nxt, tick, carry;
   assign tick = presc == PW'(TICK_DIV - 1);
   assign contando = estado == CONTANDO;
   assign estouro = estado == ESTOURO;
   // BCD increment by one: each 9 rolls to 0 and carries into the next digit
   always_comb begin
      q_inc = Q;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            q_inc[4*i +: 4] = (Q[4*i +: 4] == 4'd9) ? 4'd0 : Q[4*i +: 4] + 4'd1;
            carry = Q[4*i +: 4] == 4'd9;
         end
      end
   end
   // next state, prescaler and count; zerar overrides everything
   always_comb begin
      estado_nxt = estado;
      presc_nxt = presc;
      q_nxt = Q;
      if (zerar) begin
         estado_nxt = INICIAL;
         presc_nxt = '0;
         q_nxt = '0;
      end else begin
         case (estado)
            INICIAL: if (iniciar && !parar) begin
               estado_nxt = CONTANDO;
               presc_nxt = '0;
               q_nxt = '0;
            end
            CONTANDO: if (parar) estado_nxt = PARADO;
               else if (tick) begin
                  presc_nxt = '0;
                  estado_nxt = (Q == 16'h9999) ? ESTOURO : CONTANDO;
                  q_nxt = (Q == 16'h9999) ? Q : q_inc;
               end else presc_nxt = presc + PW'(1);
            PARADO: if (iniciar && !parar) estado_nxt = CONTANDO;
            default: estado_nxt = estado;
         endcase
      end
      pronto_nxt = (estado_nxt == PARADO && estado != PARADO) ||
                   (estado_nxt == ESTOURO && estado != ESTOURO);
   end
   // state registers; clr clears the measurement immediately
   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         estado <= INICIAL;
         presc <= '0;
         Q <= '0;
         pronto <= 1'b0;
      end else begin
         estado <= estado_nxt;
         presc <= presc_nxt;
         Q <= q_nxt;
         pronto <= pronto_nxt;
      end
   end
endmodule

// File: tb/tb_cronometro_progressivo.sv
// tb_cronometro_progressivo: directed checks of the stopwatch with TICK_DIV=4
module tb_cronometro_progressivo;
   logic clock = 1'b0;
   logic clr = 1'b1;
   logic iniciar = 1'b0;
   logic parar = 1'b0;
   logic zerar = 1'b0;
   logic [15:0] Q;
   logic contando, pronto, estouro;
   logic [18:0] obs;
   int checks = 0;
   int failures = 0;
   int elapsed = 0;

   cronometro_progressivo #(.TICK_DIV(4)) dut (
      .clock(clock), .clr(clr), .iniciar(iniciar), .parar(parar), .zerar(zerar),
      .Q(Q), .contando(contando), .pronto(pronto), .estouro(estouro)
   );

   assign obs = {Q, contando, pronto, estouro};

   // free-running clock: rising edges at 5,15,25...; inputs change and outputs sampled at falling edges
   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_start();
      iniciar = 1'b1;
      step(1);
      iniciar = 1'b0;
      elapsed = 0;
   endtask

   task automatic run_to(input int n);
      step(4 * n - elapsed);
      elapsed = 4 * n;
   endtask

   task automatic test_reset();
      #2 clr = 1'b0;
      #1;
      checks++; if (obs !== 19'h0) begin failures++; $display("FAIL reset_async obs=%h exp=%h", obs, 19'h0); end
      iniciar = 1'b1;
      step(2);
      checks++; if (obs !== 19'h0) begin failures++; $display("FAIL reset_ignores_iniciar obs=%h exp=%h", obs, 19'h0); end
      iniciar = 1'b0;
      clr = 1'b1;
      step(3);
      checks++; if (obs !== 19'h0) begin failures++; $display("FAIL reset_release_idle obs=%h exp=%h", obs, 19'h0); end
   endtask

   task automatic test_count_stop();
      do_start();
      checks++; if (obs !== {16'h0000, 3'b100}) begin failures++; $display("FAIL start_enter obs=%h exp=%h", obs, {16'h0000, 3'b100}); end
      step(3);
      checks++; if (obs !== {16'h0000, 3'b100}) begin failures++; $display("FAIL latency_before obs=%h exp=%h", obs, {16'h0000, 3'b100}); end
      step(1);
      checks++; if (obs !== {16'h0001, 3'b100}) begin failures++; $display("FAIL latency_first obs=%h exp=%h", obs, {16'h0001, 3'b100}); end
      step(36);
      checks++; if (obs !== {16'h0010, 3'b100}) begin failures++; $display("FAIL count_40 obs=%h exp=%h", obs, {16'h0010, 3'b100}); end
      parar = 1'b1;
      step(1);
      parar = 1'b0;
      checks++; if (obs !== {16'h0010, 3'b010}) begin failures++; $display("FAIL stop_pronto obs=%h exp=%h", obs, {16'h0010, 3'b010}); end
      step(1);
      checks++; if (obs !== {16'h0010, 3'b000}) begin failures++; $display("FAIL stop_pronto_once obs=%h exp=%h", obs, {16'h0010, 3'b000}); end
      step(20);
      checks++; if (obs !== {16'h0010, 3'b000}) begin failures++; $display("FAIL stop_hold obs=%h exp=%h", obs, {16'h0010, 3'b000}); end
   endtask

   task automatic test_pause_resume();
      zerar = 1'b1;
      step(1);
      zerar = 1'b0;
      checks++; if (obs !== 19'h0) begin failures++; $display("FAIL zerar_from_parado obs=%h exp=%h", obs, 19'h0); end
      do_start();
      step(2);
      parar = 1'b1;
      step(1);
      parar = 1'b0;
      checks++; if (obs !== {16'h0000, 3'b010}) begin failures++; $display("FAIL pause_presc2 obs=%h exp=%h", obs, {16'h0000, 3'b010}); end
      step(3);
      iniciar = 1'b1;
      step(1);
      iniciar = 1'b0;
      checks++; if (obs !== {16'h0000, 3'b100}) begin failures++; $display("FAIL resume_enter obs=%h exp=%h", obs, {16'h0000, 3'b100}); end
      step(1);
      checks++; if (obs !== {16'h0000, 3'b100}) begin failures++; $display("FAIL resume_wait obs=%h exp=%h", obs, {16'h0000, 3'b100}); end
      step(1);
      checks++; if (obs !== {16'h0001, 3'b100}) begin failures++; $display("FAIL resume_tick obs=%h exp=%h", obs, {16'h0001, 3'b100}); end
      iniciar = 1'b1;
      parar = 1'b1;
      step(1);
      iniciar = 1'b0;
      parar = 1'b0;
      checks++; if (obs !== {16'h0001, 3'b010}) begin failures++; $display("FAIL parar_iniciar obs=%h exp=%h", obs, {16'h0001, 3'b010}); end
      zerar = 1'b1;
      iniciar = 1'b1;
      step(1);
      zerar = 1'b0;
      iniciar = 1'b0;
      checks++; if (obs !== 19'h0) begin failures++; $display("FAIL zerar_iniciar obs=%h exp=%h", obs, 19'h0); end
      step(6);
      checks++; if (obs !== 19'h0) begin failures++; $display("FAIL zerar_stays obs=%h exp=%h", obs, 19'h0); end
   endtask

   task automatic test_midcount_clr();
      do_start();
      step(10);
      checks++; if (obs !== {16'h0002, 3'b100}) begin failures++; $display("FAIL mid_count obs=%h exp=%h", obs, {16'h0002, 3'b100}); end
      #2 clr = 1'b0;
      #1;
      checks++; if (obs !== 19'h0) begin failures++; $display("FAIL mid_clr_async obs=%h exp=%h", obs, 19'h0); end
      step(1);
      clr = 1'b1;
      step(5);
      checks++; if (obs !== 19'h0) begin failures++; $display("FAIL mid_clr_idle obs=%h exp=%h", obs, 19'h0); end
   endtask

   task automatic test_carry_overflow();
      do_start();
      run_to(98);
      checks++; if (obs !== {16'h0098, 3'b100}) begin failures++; $display("FAIL bcd_0098 obs=%h exp=%h", obs, {16'h0098, 3'b100}); end
      run_to(99);
      checks++; if (obs !== {16'h0099, 3'b100}) begin failures++; $display("FAIL bcd_0099 obs=%h exp=%h", obs, {16'h0099, 3'b100}); end
      run_to(100);
      checks++; if (obs !== {16'h0100, 3'b100}) begin failures++; $display("FAIL bcd_0100 obs=%h exp=%h", obs, {16'h0100, 3'b100}); end
      run_to(999);
      checks++; if (obs !== {16'h0999, 3'b100}) begin failures++; $display("FAIL bcd_0999 obs=%h exp=%h", obs, {16'h0999, 3'b100}); end
      run_to(1000);
      checks++; if (obs !== {16'h1000, 3'b100}) begin failures++; $display("FAIL bcd_1000 obs=%h exp=%h", obs, {16'h1000, 3'b100}); end
      run_to(9999);
      checks++; if (obs !== {16'h9999, 3'b100}) begin failures++; $display("FAIL bcd_9999 obs=%h exp=%h", obs, {16'h9999, 3'b100}); end
      run_to(10000);
      checks++; if (obs !== {16'h9999, 3'b011}) begin failures++; $display("FAIL overflow_enter obs=%h exp=%h", obs, {16'h9999, 3'b011}); end
      step(1);
      checks++; if (obs !== {16'h9999, 3'b001}) begin failures++; $display("FAIL overflow_pronto_once obs=%h exp=%h", obs, {16'h9999, 3'b001}); end
      iniciar = 1'b1;
      step(2);
      iniciar = 1'b0;
      parar = 1'b1;
      step(2);
      parar = 1'b0;
      step(4);
      checks++; if (obs !== {16'h9999, 3'b001}) begin failures++; $display("FAIL overflow_ignores obs=%h exp=%h", obs, {16'h9999, 3'b001}); end
      zerar = 1'b1;
      step(1);
      zerar = 1'b0;
      checks++; if (obs !== 19'h0) begin failures++; $display("FAIL overflow_zerar obs=%h exp=%h", obs, 19'h0); end
   endtask

   initial begin
      test_reset();
      test_count_stop();
      test_pause_resume();
      test_midcount_clr();
      test_carry_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cronometro_progressivo.md
CRONOMETRO_PROGRESSIVO -- requirements
Module: cronometro_progressivo

Interface
REQ-001 Parameter: TICK_DIV, default 50000, clock cycles per count unit (legal range 1..1048576).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 clr  input  1  asynchronous active-low reset.
REQ-005 iniciar  input  1  start/resume request, sampled on rising edge.
REQ-006 parar  input  1  stop/pause request, sampled on rising edge.
REQ-007 zerar  input  1  synchronous clear-to-zero request.
REQ-008 Q  output  16  elapsed count, 4 BCD digits {d3,d2,d1,d0}, registered.
REQ-009 contando  output  1  high while in state CONTANDO.
REQ-010 pronto  output  1  one-cycle pulse: measurement valid.
REQ-011 estouro  output  1  high while saturated at 9999.

Function
REQ-012 The block SHALL implement FSM states INICIAL, CONTANDO, PARADO and ESTOURO.
REQ-013 The block SHALL contain a prescaler counting 0..TICK_DIV-1 only in CONTANDO, producing an internal tick when it equals TICK_DIV-1 and returning to 0 on that cycle.
REQ-014 Each tick in CONTANDO SHALL increment Q by one in BCD: digit 9 wraps to 0 with carry to the next digit (0009->0010, 0099->0100, 0999->1000).
REQ-015 zerar SHALL have priority over all other inputs in every state: Q=0000, prescaler=0, pronto=0, estouro=0, next state INICIAL.
REQ-016 INICIAL: iniciar=1 and parar=0 -> CONTANDO with Q=0000 and prescaler=0; otherwise remain.
REQ-017 CONTANDO: parar=1 -> PARADO; Q and prescaler hold; the tick of that cycle, if any, SHALL NOT be counted; iniciar is ignored.
REQ-018 CONTANDO: tick while Q=9999 and parar=0 -> ESTOURO with Q held at 9999; Q never wraps to 0000.
REQ-019 PARADO: iniciar=1 and parar=0 -> CONTANDO, resuming from held Q and held prescaler value; otherwise remain.
REQ-020 ESTOURO: only zerar or clr exits; iniciar and parar are ignored.
REQ-021 pronto SHALL be 1 for exactly the one cycle after each entry into PARADO or ESTOURO, and 0 otherwise.
REQ-022 contando SHALL be 1 from the edge that enters CONTANDO to the edge that leaves it.
REQ-023 Latency: with iniciar sampled at edge k from INICIAL, the first increment SHALL appear at edge k+TICK_DIV.
REQ-024 With TICK_DIV=1, Q SHALL increment on every CONTANDO cycle.

Reset
REQ-025 clr=0 SHALL, without waiting for a clock edge, force state INICIAL, Q=0000, prescaler=0, contando=0, pronto=0 and estouro=0.
REQ-026 clr deassertion SHALL take effect on the following rising edge; no input is acted on while clr=0.
REQ-027 Reset asserted mid-count SHALL discard the measurement; no pronto pulse is produced.

Verification (TICK_DIV=4)
REQ-028 Mid-count clr pulse between edges -> Q=0000, contando=0 and estouro=0 immediately; after release the block stays in INICIAL until iniciar.
REQ-029 iniciar pulse, then 40 cycles, then parar -> Q=16'h0010, contando falls, pronto high for 1 cycle, Q holds 0010 for 20 further cycles.
REQ-030 Run from 0098 through 2 ticks -> Q=0099 then 0100; run from 0999 through 1 tick -> Q=1000.
REQ-031 Run to 9999 plus 1 tick -> Q=9999, estouro=1, one pronto pulse; iniciar then ignored; zerar -> Q=0000, estouro=0.
REQ-032 Pause with prescaler=2, then resume -> next increment after 2 cycles; parar+iniciar together in CONTANDO -> PARADO; zerar+iniciar together -> INICIAL with Q=0000.
